// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble and mispredict squash
// Optional load-use detection and bubble counter enabled by LOAD_USE_STALL_EN.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_ID,
  input  logic [XLEN-1:0]  pc_ID,
  input  logic [XLEN-1:0]  rdata1_ID,
  input  logic [XLEN-1:0]  rdata2_ID,
  input  logic [XLEN-1:0]  imm_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             ASel_ID,
  input  logic             BSel_ID,
  input  logic             RegWen_ID,
  input  logic             MemRd_ID,
  input  logic             MemWen_ID,
  input  logic             mispredict_EX,
  input  logic             stall_ext,
  output logic [XLEN-1:0]  pc_EX,
  output logic [XLEN-1:0]  rdata1_EX,
  output logic [XLEN-1:0]  rdata2_EX,
  output logic [XLEN-1:0]  imm_EX,
  output logic [4:0]       rs1_EX,
  output logic [4:0]       rs2_EX,
  output logic [4:0]       rd_EX,
  output logic             valid_EX,
  output logic             ASel_EX,
  output logic             BSel_EX,
  output logic             RegWen_EX,
  output logic             MemRd_EX,
  output logic             MemWen_EX,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             flush_ID,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            asel;
    logic            bsel;
    logic            regwen;
    logic            memrd;
    logic            memwen;
  } ex_t;

  state_t state_q, state_d;
  ex_t    ex_q, ex_d, id_pkt;
  logic   lu;

  always_comb begin
    id_pkt        = '0;
    id_pkt.valid  = 1'b1;
    id_pkt.pc     = pc_ID;
    id_pkt.rdata1 = rdata1_ID;
    id_pkt.rdata2 = rdata2_ID;
    id_pkt.imm    = imm_ID;
    id_pkt.rs1    = rs1_ID;
    id_pkt.rs2    = rs2_ID;
    id_pkt.rd     = rd_ID;
    id_pkt.asel   = ASel_ID;
    id_pkt.bsel   = BSel_ID;
    id_pkt.regwen = RegWen_ID;
    id_pkt.memrd  = MemRd_ID;
    id_pkt.memwen = MemWen_ID;
  end

`ifdef LOAD_USE_STALL_EN
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // EX holds a bubble in LU_STALL, so the state gate only makes that explicit.
  assign lu = (state_q != LU_STALL) & ex_q.valid & ex_q.memrd & (ex_q.rd != 5'd0) & valid_ID &
              ((use_rs1_ID & (rs1_ID == ex_q.rd)) | (use_rs2_ID & (rs2_ID == ex_q.rd)));
  assign cnt_inc = lu & ~mispredict_EX & ~stall_ext;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign lu_stall_cnt = cnt_q;
`else
  logic unused_lu_inputs;
  assign unused_lu_inputs = ^{use_rs1_ID, use_rs2_ID};
  assign lu               = 1'b0;
  assign lu_stall_cnt     = '0;
`endif

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    if (mispredict_EX) begin
      ex_d    = '0;
      state_d = FLUSH;
    end else if (stall_ext) begin
      ex_d    = ex_q;
      state_d = state_q;
    end else if (lu) begin
      ex_d    = '0;
      state_d = LU_STALL;
    end else begin
      ex_d    = valid_ID ? id_pkt : '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      state_q <= RUN;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

  // The flush must win over any stall so the upstream redirect is never held off.
  assign flush_ID = rst_n & mispredict_EX;
  assign stall_IF = rst_n & ~mispredict_EX & (stall_ext | lu);
  assign stall_ID = stall_IF;

  assign valid_EX  = ex_q.valid;
  assign pc_EX     = ex_q.pc;
  assign rdata1_EX = ex_q.rdata1;
  assign rdata2_EX = ex_q.rdata2;
  assign imm_EX    = ex_q.imm;
  assign rs1_EX    = ex_q.rs1;
  assign rs2_EX    = ex_q.rs2;
  assign rd_EX     = ex_q.rd;
  assign ASel_EX   = ex_q.asel;
  assign BSel_EX   = ex_q.bsel;
  assign RegWen_EX = ex_q.regwen;
  assign MemRd_EX  = ex_q.memrd;
  assign MemWen_EX = ex_q.memwen;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed check of id_ex_stage against a reference model
module tb_id_ex_stage;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LOAD_USE_STALL_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic clk, rst_n;
  logic valid_ID, use_rs1_ID, use_rs2_ID, ASel_ID, BSel_ID, RegWen_ID, MemRd_ID, MemWen_ID;
  logic [31:0] pc_ID, rdata1_ID, rdata2_ID, imm_ID;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic mispredict_EX, stall_ext;
  logic [31:0] pc_EX, rdata1_EX, rdata2_EX, imm_EX;
  logic [4:0] rs1_EX, rs2_EX, rd_EX;
  logic valid_EX, ASel_EX, BSel_EX, RegWen_EX, MemRd_EX, MemWen_EX;
  logic stall_IF, stall_ID, flush_ID;
  logic [CNT_W-1:0] lu_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
    .pc_ID(pc_ID), .rdata1_ID(rdata1_ID), .rdata2_ID(rdata2_ID), .imm_ID(imm_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .ASel_ID(ASel_ID), .BSel_ID(BSel_ID), .RegWen_ID(RegWen_ID), .MemRd_ID(MemRd_ID), .MemWen_ID(MemWen_ID),
    .mispredict_EX(mispredict_EX), .stall_ext(stall_ext),
    .pc_EX(pc_EX), .rdata1_EX(rdata1_EX), .rdata2_EX(rdata2_EX), .imm_EX(imm_EX),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .valid_EX(valid_EX),
    .ASel_EX(ASel_EX), .BSel_EX(BSel_EX), .RegWen_EX(RegWen_EX), .MemRd_EX(MemRd_EX), .MemWen_EX(MemWen_EX),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID), .lu_stall_cnt(lu_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the instruction currently sitting in EX (all-zero record = bubble).
  typedef struct packed {
    logic v;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0] rs1, rs2, rd;
    logic a, b, rw, mr, mw;
  } rec_t;

  rec_t m;
  int   mcnt;

  function automatic logic model_lu();
    return LU_EN && m.v && m.mr && (m.rd != 5'd0) && valid_ID &&
           ((use_rs1_ID && rs1_ID == m.rd) || (use_rs2_ID && rs2_ID == m.rd));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '0;
      mcnt <= 0;
    end else if (mispredict_EX) begin
      m <= '0;
    end else if (stall_ext) begin
      m <= m;
    end else if (model_lu()) begin
      m <= '0;
      if (mcnt < CNT_MAX) mcnt <= mcnt + 1;
    end else if (valid_ID) begin
      m <= {1'b1, pc_ID, rdata1_ID, rdata2_ID, imm_ID, rs1_ID, rs2_ID, rd_ID,
            ASel_ID, BSel_ID, RegWen_ID, MemRd_ID, MemWen_ID};
    end else begin
      m <= '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic stl;
    stl = rst_n && !mispredict_EX && (stall_ext || model_lu());
    chk("valid_EX", valid_EX, m.v);
    chk("pc_EX", pc_EX, m.pc);
    chk("rdata1_EX", rdata1_EX, m.r1);
    chk("rdata2_EX", rdata2_EX, m.r2);
    chk("imm_EX", imm_EX, m.imm);
    chk("rs1_EX", rs1_EX, m.rs1);
    chk("rs2_EX", rs2_EX, m.rs2);
    chk("rd_EX", rd_EX, m.rd);
    chk("ctrl_EX", {ASel_EX, BSel_EX, RegWen_EX, MemRd_EX, MemWen_EX}, {m.a, m.b, m.rw, m.mr, m.mw});
    chk("stall_IF", stall_IF, stl);
    chk("stall_ID", stall_ID, stl);
    chk("flush_ID", flush_ID, rst_n && mispredict_EX);
    chk("lu_stall_cnt", lu_stall_cnt, mcnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid_ID = 0; pc_ID = 0; rdata1_ID = 0; rdata2_ID = 0; imm_ID = 0;
    rs1_ID = 0; rs2_ID = 0; rd_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0;
    ASel_ID = 0; BSel_ID = 0; RegWen_ID = 0; MemRd_ID = 0; MemWen_ID = 0;
    mispredict_EX = 0; stall_ext = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic u1, input logic u2,
                       input logic mr, input logic rw);
    valid_ID = 1; pc_ID = pc; rs1_ID = s1; rs2_ID = s2; rd_ID = d;
    use_rs1_ID = u1; use_rs2_ID = u2; MemRd_ID = mr; RegWen_ID = rw;
    rdata1_ID = $urandom; rdata2_ID = $urandom; imm_ID = $urandom;
    ASel_ID = 1'($urandom); BSel_ID = 1'($urandom); MemWen_ID = 0;
  endtask

  initial begin
    rst_n = 0;
    clr();
    repeat (3) tick();
    chk("rst pc_EX", pc_EX, 32'h0);
    chk("rst valid_EX", valid_EX, 0);
    chk("rst cnt", lu_stall_cnt, 0);
    chk("rst stall_IF", stall_IF, 0);
    chk("rst flush_ID", flush_ID, 0);
    rst_n = 1;
    tick();

    // normal advance
    instr(32'h100, 0, 0, 5, 0, 0, 0, 1);
    tick();
    chk("adv pc_EX", pc_EX, 32'h100);
    chk("adv rd_EX", rd_EX, 5);
    chk("adv RegWen_EX", RegWen_EX, 1);
    chk("adv valid_EX", valid_EX, 1);

    // load-use: lw x3 then add reading x3 via rs2
    instr(32'h104, 0, 0, 3, 0, 0, 1, 1);
    tick();
    instr(32'h108, 1, 3, 7, 1, 1, 0, 1);
    #1;
    chk("lu stall_IF", stall_IF, LU_EN);
    chk("lu stall_ID", stall_ID, LU_EN);
    tick();
    chk("lu valid_EX", valid_EX, !LU_EN);
    chk("lu rd_EX", rd_EX, LU_EN ? 0 : 7);
    chk("lu cnt", lu_stall_cnt, LU_EN ? 1 : 0);
    chk("lu bubble stall_ID", stall_ID, 0);
    tick();
    chk("lu add rs2_EX", rs2_EX, 3);
    chk("lu add rd_EX", rd_EX, 7);

    // rd=0 load and unused-source match never stall
    instr(32'h10c, 0, 0, 0, 0, 0, 1, 1);
    tick();
    instr(32'h110, 0, 0, 8, 1, 1, 0, 1);
    #1;
    chk("rd0 stall_ID", stall_ID, 0);
    tick();
    instr(32'h114, 0, 0, 4, 0, 0, 1, 1);
    tick();
    instr(32'h118, 4, 9, 8, 0, 1, 0, 1);
    #1;
    chk("unused stall_ID", stall_ID, 0);
    tick();

    // mispredict coinciding with load-use
    instr(32'h11c, 0, 0, 6, 0, 0, 1, 1);
    tick();
    instr(32'h120, 6, 0, 8, 1, 0, 0, 1);
    mispredict_EX = 1;
    #1;
    chk("mp flush_ID", flush_ID, 1);
    chk("mp stall_ID", stall_ID, 0);
    chk("mp stall_IF", stall_IF, 0);
    tick();
    mispredict_EX = 0;
    chk("mp valid_EX", valid_EX, 0);
    chk("mp rd_EX", rd_EX, 0);
    chk("mp cnt", lu_stall_cnt, LU_EN ? 1 : 0);
    #1;
    chk("flush-state stall_ID", stall_ID, 0);
    tick();
    chk("after flush pc_EX", pc_EX, 32'h120);

    // stall_ext freezes EX for three cycles while ID changes
    instr(32'h200, 0, 0, 9, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      instr(32'h300 + 32'(4 * i), 1, 2, 5'(10 + i), 1, 1, 0, 1);
      stall_ext = 1;
      #1;
      chk("sx stall_IF", stall_IF, 1);
      tick();
      chk("sx pc_EX", pc_EX, 32'h200);
      chk("sx rd_EX", rd_EX, 9);
    end
    stall_ext = 0;

    // stall_ext together with load-use: hold, no count, then re-evaluate
    instr(32'h204, 0, 0, 11, 0, 0, 1, 1);
    tick();
    instr(32'h208, 11, 0, 12, 1, 0, 0, 1);
    stall_ext = 1;
    #1;
    chk("sxlu stall_ID", stall_ID, 1);
    tick();
    chk("sxlu cnt", lu_stall_cnt, LU_EN ? 1 : 0);
    chk("sxlu pc_EX", pc_EX, 32'h204);
    stall_ext = 0;
    #1;
    chk("sxlu release stall_ID", stall_ID, LU_EN);
    tick();
    chk("sxlu cnt2", lu_stall_cnt, LU_EN ? 2 : 0);
    chk("sxlu valid_EX", valid_EX, !LU_EN);

    // reset asserted in the bubble cycle
    rst_n = 0;
    #1;
    chk("rstmid valid_EX", valid_EX, 0);
    chk("rstmid cnt", lu_stall_cnt, 0);
    chk("rstmid stall_IF", stall_IF, 0);
    clr();
    tick();
    rst_n = 1;
    tick();

    // counter saturation
    for (int k = 0; k < 10; k++) begin
      instr(32'h400, 0, 0, 3, 0, 0, 1, 1);
      tick();
      instr(32'h404, 3, 0, 5, 1, 0, 0, 1);
      tick();
      tick();
    end
    chk("sat cnt", lu_stall_cnt, LU_EN ? CNT_MAX : 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      instr($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), $urandom_range(0, 9) < 4, 1'($urandom));
      valid_ID = $urandom_range(0, 9) < 8;
      MemWen_ID = 1'($urandom);
      mispredict_EX = $urandom_range(0, 9) == 0;
      stall_ext = $urandom_range(0, 19) < 3;
      tick();
    end
    rst_n = 1;
    clr();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
